// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    // 500 ms hold before the first repeat, then 100 ms between repeats
    localparam int REPEAT_DELAY_DEF    = 25000000;
    localparam int REPEAT_PERIOD_DEF   = 5000000;

endpackage

// File: rtl/key_debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM, registered pulses.
// Optional auto-repeat of the press pulse when KEY_AUTOREPEAT_EN is defined.
//
// state        | meaning
// IDLE         | key accepted as released, waiting for a pressed sample
// PRESS_WAIT   | pressed level seen, counting stable cycles before accepting
// PRESSED      | key accepted as pressed, held high
// RELEASE_WAIT | released level seen, counting stable cycles before accepting
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n_i,
    output logic press_o,
    output logic release_o,
    output logic held_o
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam int             RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             RW         = $clog2(RMAX + 1);
    // Down-counter reloads; a pulse fires on the cycle after it reaches zero.
    localparam logic [RW-1:0]  RPT_FIRST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RPT_NEXT   = RW'(REPEAT_PERIOD - 1);
`endif

    logic          sync1_q, sync2_q;
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          held_q, held_d;
`ifdef KEY_AUTOREPEAT_EN
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    // Bring the active-high pressed level into the clock domain.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            held_q    <= held_d;
`ifdef KEY_AUTOREPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    // Next-state and pulse decode; cnt is cleared on every state entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held_q;
`ifdef KEY_AUTOREPEAT_EN
        rpt_d     = rpt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    held_d  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_d   = RPT_FIRST;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_d   = '0;
                end else if (rpt_q == '0) begin
                    press_d = 1'b1;
                    rpt_d   = RPT_NEXT;
                end else begin
                    rpt_d = rpt_q - RW'(1);
`endif
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    // Bounce back to pressed: no pulse, repeat timing restarts.
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_d   = RPT_FIRST;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign held_o    = held_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low push-buttons into clean press/release pulses
// and a held level. Define KEY_AUTOREPEAT_EN to add press auto-repeat.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] key_n_i,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] held_o
);

    // Independent identical channels, no arbitration between them.
    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_chan (
            .CLOCK_50  (CLOCK_50),
            .resetn    (resetn),
            .key_n_i   (key_n_i[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .held_o    (held_o[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    localparam int N  = 4;
    localparam int D  = 8;
`ifdef KEY_AUTOREPEAT_EN
    localparam int RD = 20;
    localparam int RP = 6;
`endif

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] key_n  = '1;
    logic [N-1:0] press_o, release_o, held_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .key_n_i   (key_n),
        .press_o   (press_o),
        .release_o (release_o),
        .held_o    (held_o)
    );

    // Reference model: a key level is accepted once the sampled level has
    // disagreed with the accepted level for D+1 consecutive clock samples.
    typedef struct packed {
        int   run;
        int   age;
        logic held;
        logic pr;
        logic rl;
    } ch_t;

    function automatic ch_t step(input logic smp, input ch_t c);
        ch_t n;
        n    = c;
        n.pr = 1'b0;
        n.rl = 1'b0;
        if (smp != c.held) begin
            n.run = c.run + 1;
            if (n.run == D + 1) begin
                n.held = smp;
                n.run  = 0;
                n.age  = 0;
                n.pr   = smp;
                n.rl   = ~smp;
            end
        end else begin
            if (c.held) begin
                if (c.run != 0) begin
                    n.age = 0;
                end else begin
                    n.age = c.age + 1;
`ifdef KEY_AUTOREPEAT_EN
                    if (n.age == RD || (n.age > RD && ((n.age - RD) % RP) == 0))
                        n.pr = 1'b1;
`endif
                end
            end
            n.run = 0;
        end
        return n;
    endfunction

    logic [N-1:0] m_d1, m_d2;
    ch_t          m_ch [N];
    logic [N-1:0] exp_p, exp_r, exp_h;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_d1 <= '0;
            m_d2 <= '0;
            for (int i = 0; i < N; i++) m_ch[i] <= '0;
        end else begin
            m_d1 <= ~key_n;
            m_d2 <= m_d1;
            for (int i = 0; i < N; i++) m_ch[i] <= step(m_d2[i], m_ch[i]);
        end
    end

    always_comb begin
        exp_p = '0;
        exp_r = '0;
        exp_h = '0;
        for (int i = 0; i < N; i++) begin
            exp_p[i] = m_ch[i].pr;
            exp_r[i] = m_ch[i].rl;
            exp_h[i] = m_ch[i].held;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (press_o !== exp_p || release_o !== exp_r || held_o !== exp_h) begin
                failures++;
                $display("FAIL model_cmp t=%0t press=%b/%b release=%b/%b held=%b/%b",
                         $time, press_o, exp_p, release_o, exp_r, held_o, exp_h);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Edge index (0 = first posedge after the drive) at which the pulse is seen.
    task automatic wait_pulse(input int ch, input bit rel_sel, output int lat);
        lat = -1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (rel_sel ? release_o[ch] : press_o[ch]) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic watch(input int n, input int ch, inout int cnt);
        repeat (n) begin
            @(negedge clk);
            if (press_o[ch]) cnt++;
            @(posedge clk);
            #2;
        end
    endtask

    int lat;
    int cnt;
    int rem [N];
`ifdef KEY_AUTOREPEAT_EN
    int hits[$];
`endif

    initial begin
        resetn = 1'b0;
        key_n  = '1;
        cyc(3);
        check("reset_outputs", int'({press_o, release_o, held_o}), 0);
        resetn = 1'b1;
        cyc(2);

        // single press on key 0
        key_n[0] = 1'b0;
        wait_pulse(0, 1'b0, lat);
        check("k0_press_latency", lat, D + 2);
        check("k0_held", int'(held_o[0]), 1);
        check("k0_others_quiet", int'(press_o[3:1]), 0);
        @(negedge clk);
        check("k0_press_width", int'(press_o[0]), 0);
        cyc(1);
        key_n[0] = 1'b1;
        wait_pulse(0, 1'b1, lat);
        check("k0_release_latency", lat, D + 2);
        cyc(5);

        // short glitches on key 1
        cnt = 0;
        key_n[1] = 1'b0;
        watch(5, 1, cnt);
        key_n[1] = 1'b1;
        watch(1, 1, cnt);
        key_n[1] = 1'b0;
        watch(5, 1, cnt);
        key_n[1] = 1'b1;
        watch(20, 1, cnt);
        check("k1_glitch_presses", cnt, 0);
        check("k1_glitch_held", int'(held_o[1]), 0);

        // key 2 release with a low bounce
        key_n[2] = 1'b0;
        wait_pulse(2, 1'b0, lat);
        check("k2_press_latency", lat, D + 2);
        cyc(3);
        cnt = 0;
        key_n[2] = 1'b1;
        watch(2, 2, cnt);
        key_n[2] = 1'b0;
        watch(3, 2, cnt);
        key_n[2] = 1'b1;
        wait_pulse(2, 1'b1, lat);
        check("k2_bounce_presses", cnt, 0);
        check("k2_release_latency", lat, D + 2);
        check("k2_held_falls", int'(held_o[2]), 0);
        cyc(5);

        // simultaneous keys 0 and 3
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        wait_pulse(0, 1'b0, lat);
        check("k03_latency", lat, D + 2);
        check("k03_same_cycle", int'(press_o[3]), 1);
        cyc(2);
        key_n = '1;
        cyc(20);

        // reset in the middle of PRESS_WAIT with key 1 held
        key_n[1] = 1'b0;
        cyc(5);
        resetn = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if ({press_o, release_o, held_o} != '0) cnt++;
        end
        check("reset_mid_outputs", cnt, 0);
        cyc(1);
        resetn = 1'b1;
        wait_pulse(1, 1'b0, lat);
        check("post_reset_latency", lat, D + 2);
        cyc(2);
        key_n = '1;
        cyc(20);

`ifdef KEY_AUTOREPEAT_EN
        key_n[0] = 1'b0;
        wait_pulse(0, 1'b0, lat);
        check("rpt_accept_latency", lat, D + 2);
        hits.delete();
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (press_o[0]) hits.push_back(k);
        end
        cyc(1);
        key_n[0] = 1'b1;
        check("rpt_count", hits.size(), 6);
        for (int i = 0; i < hits.size(); i++) check("rpt_offset", hits[i], RD + RP * i);
        cnt = 0;
        watch(30, 0, cnt);
        check("rpt_after_release", cnt, 0);
        cyc(5);
`endif

        // randomized bouncing on all channels
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 40)
                                                         : $urandom_range(1, 10);
                end else begin
                    rem[i] = rem[i] - 1;
                end
            end
            if (c == 1500) begin
                resetn = 1'b0;
                cyc(2);
                resetn = 1'b1;
            end
            cyc(1);
        end
        key_n = '1;
        cyc(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
